// File: rtl/led_mmio_ctrl_pkg.sv
// Shared constants and helpers for the LED memory-mapped write port.
package led_mmio_ctrl_pkg;

    localparam logic [31:0] LED_ADDR_DEFAULT  = 32'hFFFF_F060;
    localparam logic [31:0] CTRL_ADDR_DEFAULT = 32'hFFFF_F064;
    localparam logic [23:0] LED_OFF           = 24'hFFFFFF;

    // Replace each enabled byte lane of the 24-bit pattern with store data.
    function automatic logic [23:0] merge_lanes(input logic [23:0] old_val,
                                                input logic [23:0] wdata,
                                                input logic [2:0]  be);
        logic [23:0] res;
        res = old_val;
        for (int i = 0; i < 3; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_mmio_ctrl_if.sv
// MEM-stage store/load bus as seen by the LED controller.
// bus_we is a one-cycle strobe with no ready: every store is accepted on the edge it is presented.
interface led_mmio_ctrl_if;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_we, bus_addr, bus_be, bus_wdata, input bus_rdata);
    modport slave  (input bus_we, bus_addr, bus_be, bus_wdata, output bus_rdata);
endinterface

// File: rtl/led_mmio_ctrl_blink_tick_gen.sv
// Blink prescaler: toggles phase every TICK_DIV cycles while en is high.
module blink_tick_gen #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] counter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (!en) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (counter == LAST) begin
            counter <= '0;
            phase   <= ~phase;
        end else begin
            counter <= counter + 1'b1;
        end
    end

endmodule

// File: rtl/led_mmio_ctrl.sv
// Decodes stores to the LED data/control words, keeps the shadow pattern,
// and emits a one-cycle led_we pulse whenever the displayed pattern changes.
module led_mmio_ctrl
    import led_mmio_ctrl_pkg::*;
#(
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DEFAULT,
    parameter logic [31:0] CTRL_ADDR = CTRL_ADDR_DEFAULT,
    parameter int          TICK_DIV  = 25_000_000,
    parameter int          CNT_W     = 32
) (
    input  logic             led_clk,
    input  logic             led_rst,
    led_mmio_ctrl_if.slave   bus,
    output logic             led_we,
    output logic [31:0]      led_wdata
);

    logic [23:0] shadow, shadow_next, eff;
    logic        blink_en, blink_en_next, tick_en, phase;
    logic        led_hit, ctrl_hit;

    assign led_hit  = (bus.bus_addr[31:2] == LED_ADDR[31:2]);
    assign ctrl_hit = (bus.bus_addr[31:2] == CTRL_ADDR[31:2]);

    always_comb begin
        shadow_next   = shadow;
        blink_en_next = blink_en;
        if (bus.bus_we && led_hit)
            shadow_next = merge_lanes(shadow, bus.bus_wdata[23:0], bus.bus_be[2:0]);
        if (bus.bus_we && ctrl_hit && bus.bus_be[0])
            blink_en_next = bus.bus_wdata[0];
    end

    // Gating with both the current and next enable clears the prescaler on the
    // disabling write edge, and holds it at zero on the enabling edge.
    assign tick_en = blink_en & blink_en_next;

    blink_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk   (led_clk),
        .rst   (led_rst),
        .en    (tick_en),
        .phase (phase)
    );

    assign eff = phase ? LED_OFF : shadow;

    always_ff @(posedge led_clk or posedge led_rst) begin
        if (led_rst) begin
            shadow    <= LED_OFF;
            blink_en  <= 1'b0;
            led_we    <= 1'b0;
            led_wdata <= {8'h00, LED_OFF};
        end else begin
            shadow    <= shadow_next;
            blink_en  <= blink_en_next;
            led_we    <= (eff != led_wdata[23:0]);
            led_wdata <= {8'h00, eff};
        end
    end

    // Software reads the shadow, not the blanked pattern.
    always_comb begin
        bus.bus_rdata = 32'h0;
        if (led_hit)
            bus.bus_rdata = {8'h00, shadow};
        else if (ctrl_hit)
            bus.bus_rdata = {31'b0, blink_en};
    end

    logic unused_bus;
    assign unused_bus = &{1'b0, bus.bus_addr[1:0], bus.bus_be[3], bus.bus_wdata[31:24]};

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Directed checks of the LED MMIO controller with a short blink period.
module tb_led_mmio_ctrl;

    localparam logic [31:0] LED_A  = 32'hFFFF_F060;
    localparam logic [31:0] CTRL_A = 32'hFFFF_F064;
    localparam logic [31:0] MISS_A = 32'hFFFF_F068;

    logic        led_clk = 1'b0;
    logic        led_rst;
    logic        led_we;
    logic [31:0] led_wdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    led_mmio_ctrl_if bus_if();

    led_mmio_ctrl #(.TICK_DIV(4), .CNT_W(8)) dut (
        .led_clk   (led_clk),
        .led_rst   (led_rst),
        .bus       (bus_if.slave),
        .led_we    (led_we),
        .led_wdata (led_wdata)
    );

    // clock / reset
    always #5 led_clk = ~led_clk;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge led_clk);
        #2;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_if.bus_we    = 1'b1;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = data;
        bus_if.bus_be    = be;
        step();
        bus_if.bus_we    = 1'b0;
        bus_if.bus_be    = 4'h0;
        bus_if.bus_addr  = 32'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.bus_addr = addr;
        #1;
        chk(tag, {1'b0, bus_if.bus_rdata}, {1'b0, exp});
    endtask

    task automatic out_chk(input string tag, input logic we, input logic [31:0] data);
        chk(tag, {led_we, led_wdata}, {we, data});
    endtask

    task automatic sb_step(input string tag);
        logic [32:0] e;
        step();
        e = exp_q.pop_front();
        chk(tag, {led_we, led_wdata}, e);
    endtask

    initial begin
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = 32'h0;
        bus_if.bus_be    = 4'h0;
        bus_if.bus_wdata = 32'h0;
        led_rst = 1'b1;
        step();
        step();
        led_rst = 1'b0;
        step();

        out_chk("reset_out", 1'b0, 32'h00FFFFFF);
        rd_chk("reset_rd_led", LED_A, 32'h00FFFFFF);
        rd_chk("reset_rd_ctrl", CTRL_A, 32'h0);

        // full word write
        store(LED_A, 32'hAA123456, 4'hF);
        out_chk("full_n0", 1'b0, 32'h00FFFFFF);
        step();
        out_chk("full_n1", 1'b1, 32'h00123456);
        step();
        out_chk("full_n2", 1'b0, 32'h00123456);
        rd_chk("full_rd", LED_A, 32'h00123456);

        // byte merge, then the identical store again
        store(LED_A, 32'h0000FF00, 4'b0010);
        step();
        out_chk("merge_n1", 1'b1, 32'h0012FF56);
        step();
        out_chk("merge_n2", 1'b0, 32'h0012FF56);
        store(LED_A, 32'h0000FF00, 4'b0010);
        step();
        out_chk("merge_rep_n1", 1'b0, 32'h0012FF56);
        step();
        out_chk("merge_rep_n2", 1'b0, 32'h0012FF56);

        // lane 3 and empty enables change nothing
        store(LED_A, 32'hFF000000, 4'b1000);
        store(LED_A, 32'h00000000, 4'b0000);
        step();
        out_chk("be_ignored", 1'b0, 32'h0012FF56);
        rd_chk("be_ignored_rd", LED_A, 32'h0012FF56);

        // decode miss
        store(MISS_A, 32'h12345678, 4'hF);
        step();
        out_chk("miss_out", 1'b0, 32'h0012FF56);
        rd_chk("miss_rd", MISS_A, 32'h0);
        rd_chk("miss_rd_led", LED_A, 32'h0012FF56);
        rd_chk("miss_rd_ctrl", CTRL_A, 32'h0);

        // blink: settle shadow, then enable at edge N
        store(LED_A, 32'h0000F00F, 4'h7);
        step();
        step();
        out_chk("blink_pre", 1'b0, 32'h0000F00F);
        store(CTRL_A, 32'h1, 4'h1);
        rd_chk("blink_rd_ctrl", CTRL_A, 32'h1);
        for (int k = 1; k <= 20; k++) begin
            logic [31:0] d;
            logic        w;
            d = (((k - 1) / 4) % 2 == 1) ? 32'h00FFFFFF : 32'h0000F00F;
            w = (k >= 5) && ((k - 1) % 4 == 0);
            exp_q.push_back({w, d});
        end
        for (int k = 1; k <= 20; k++) sb_step($sformatf("blink_k%0d", k));

        // disable while blanked: blank pulse then unblank pulse back to back
        store(CTRL_A, 32'h0, 4'h1);
        out_chk("unblink_k21", 1'b1, 32'h00FFFFFF);
        step();
        out_chk("unblink_k22", 1'b1, 32'h0000F00F);
        for (int k = 0; k < 8; k++) step();
        out_chk("blink_stopped", 1'b0, 32'h0000F00F);

        // collision: LED write on the toggle-to-blank edge M+4
        store(CTRL_A, 32'h1, 4'h1);
        step();
        step();
        step();
        store(LED_A, 32'h00ABCDEF, 4'h7);
        out_chk("coll_k4", 1'b0, 32'h0000F00F);
        step();
        out_chk("coll_k5", 1'b1, 32'h00FFFFFF);
        step();
        out_chk("coll_k6", 1'b0, 32'h00FFFFFF);
        rd_chk("coll_rd", LED_A, 32'h00ABCDEF);
        step();
        step();
        step();
        out_chk("coll_k9", 1'b1, 32'h00ABCDEF);
        store(CTRL_A, 32'h0, 4'h1);
        step();
        out_chk("coll_off", 1'b0, 32'h00ABCDEF);

        // reset asserted in the middle of a pulse
        store(LED_A, 32'h00111111, 4'h7);
        step();
        out_chk("rst_pre", 1'b1, 32'h00111111);
        #1 led_rst = 1'b1;
        #1;
        out_chk("rst_mid", 1'b0, 32'h00FFFFFF);
        rd_chk("rst_rd_led", LED_A, 32'h00FFFFFF);
        step();
        led_rst = 1'b0;
        step();
        out_chk("rst_after", 1'b0, 32'h00FFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
